window_buffer_param: RTL and testbench

//   Parametrised K x K sliding-window generator for streaming raster video.

---
 rtl/vid_pkg.sv | 14 +
 rtl/window_buffer_param_line_buffer.sv | 28 ++
 rtl/window_buffer_param.sv | 159 +++++++++++++++
 tb/tb_window_buffer_param.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared video types and helpers for the sliding-window datapath.
// Holds the default pixel width, the pixel type and the window index helper.
package vid_pkg;

    localparam int PIX_W_DEF = 10;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    // Flat element index of window element (r,c) in a K x K window.
    function automatic int WIN_IDX(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/window_buffer_param_line_buffer.sv
// One-line delay: a RAM ring addressed by column, read-before-write.
// The read is combinational, so dout is the value stored one line earlier.
module line_buffer
    import vid_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int PIX_W = PIX_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign dout = mem[addr];

    // Store the incoming pixel after its slot has been read out.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/window_buffer_param.sv
// K x K sliding-window generator with in-frame valid gating.
// Define COORD_OUT_EN to add the win_x/win_y window-centre outputs.
module window_buffer_param
    import vid_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int K     = 7,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    input  logic                   sof,
    output logic [K*K*PIX_W-1:0]   win_out,
    output logic                   win_valid
`ifdef COORD_OUT_EN
    ,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    logic [CW-1:0] col_q, col_d, pos_col;
    logic [RW-1:0] row_q, row_d, pos_row;

    logic [PIX_W-1:0] tap [K];
    logic [PIX_W-1:0] win_q [K][K];
    logic [PIX_W-1:0] win_d [K][K];

    logic win_valid_q, win_valid_d;

    // Position of the current pixel; sof snaps it to the frame origin.
    always_comb begin
        pos_col = sof ? '0 : col_q;
        pos_row = sof ? '0 : row_q;
    end

    // Advance the raster counters on each accepted pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end
        end
    end

    assign tap[0] = pix_in;

    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        line_buffer #(
            .DEPTH (IMG_W),
            .PIX_W (PIX_W)
        ) u_lb (
            .clk  (clk),
            .en   (pix_valid),
            .addr (pos_col),
            .din  (tap[i]),
            .dout (tap[i+1])
        );
    end

    // Shift each window row left-to-right, feeding column 0 from its tap.
    always_comb begin
        win_d = win_q;
        if (pix_valid) begin
            for (int r = 0; r < K; r++) begin
                win_d[r][0] = tap[r];
                for (int c = 1; c < K; c++) begin
                    win_d[r][c] = win_q[r][c-1];
                end
            end
        end
    end

    // Valid only for accepted pixels whose window lies inside the frame.
    always_comb begin
        win_valid_d = pix_valid && (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
    end

    // Counter, window and valid registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    // Flatten the window into the output bus.
    always_comb begin
        win_out = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_out[WIN_IDX(r, c, K)*PIX_W +: PIX_W] = win_q[r][c];
            end
        end
    end

    assign win_valid = win_valid_q;

`ifdef COORD_OUT_EN
    localparam logic [CW-1:0] HALF_C = CW'((K - 1) / 2);
    localparam logic [RW-1:0] HALF_R = RW'((K - 1) / 2);

    logic [CW-1:0] x_q, x_d;
    logic [RW-1:0] y_q, y_d;

    // Window centre tracks the accepted pixel, offset by half a window.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_valid) begin
            x_d = pos_col - HALF_C;
            y_d = pos_row - HALF_R;
        end
    end

    // Coordinate registers, aligned with win_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign win_x = x_q;
    assign win_y = y_q;
`endif

endmodule

// File: tb/tb_window_buffer_param.sv
// Self-checking bench for window_buffer_param (K=3, 8x6 frame).
// Reference model keeps the whole frame image and reads windows from it.
module tb_window_buffer_param;
    import vid_pkg::*;

    localparam int K  = 3;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int P  = 10;
    localparam int VW = K * K * P;

    logic          clk = 1'b0;
    logic          reset;
    logic [P-1:0]  pix_in;
    logic          pix_valid;
    logic          sof;
    logic [VW-1:0] win_out;
    logic          win_valid;
`ifdef COORD_OUT_EN
    logic [$clog2(W)-1:0] win_x;
    logic [$clog2(H)-1:0] win_y;
`endif

    window_buffer_param #(
        .PIX_W (P),
        .K     (K),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .win_out   (win_out),
        .win_valid (win_valid)
`ifdef COORD_OUT_EN
        ,
        .win_x     (win_x),
        .win_y     (win_y)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int mr = 0;
    int mc = 0;
    bit want_first = 0;
    pixel_t frame [H][W];

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, update the model, sample 1 time unit later.
    task automatic step(input bit v, input bit s, input pixel_t d);
        int pr;
        int pc;
        bit ev;
        logic [VW-1:0] ew;
        pix_valid = v;
        sof       = s;
        pix_in    = d;
        ev = 0;
        ew = '0;
        pr = 0;
        pc = 0;
        @(posedge clk);
        if (v) begin
            pr = s ? 0 : mr;
            pc = s ? 0 : mc;
            frame[pr][pc] = d;
            if (pr >= K - 1 && pc >= K - 1) begin
                ev = 1;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        ew[(r*K+c)*P +: P] = frame[pr-r][pc-c];
            end
            if (pc == W - 1) begin
                mc = 0;
                mr = (pr == H - 1) ? 0 : pr + 1;
            end else begin
                mc = pc + 1;
                mr = pr;
            end
        end
        #1;
        chk("win_valid", VW'(win_valid), VW'(ev));
        if (ev) begin
            chk("win_out", win_out, ew);
`ifdef COORD_OUT_EN
            chk("win_x", VW'(win_x), VW'(pc - 1));
            chk("win_y", VW'(win_y), VW'(pr - 1));
`endif
            if (want_first) begin
                chk("first_00", VW'(win_out[P-1:0]), VW'('h22));
                chk("first_22", VW'(win_out[8*P +: P]), VW'(0));
                want_first = 0;
            end
        end
        if (win_valid) pulses++;
    endtask

    // One frame from (0,0); gap_pct percent chance of idle cycles per pixel.
    task automatic run_frame(input bit with_sof, input int gap_pct, input bit rnd);
        pixel_t d;
        for (int i = 0; i < W * H; i++) begin
            while ($urandom_range(0, 99) < gap_pct)
                step(0, 1'($urandom_range(0, 1)), pixel_t'($urandom));
            d = rnd ? pixel_t'($urandom) : pixel_t'((i / W) * 16 + i % W);
            step(1, with_sof && i == 0, d);
        end
    endtask

    task automatic async_reset();
        pix_valid = 0;
        sof = 0;
        #3;
        reset = 1;
        #1;
        chk("rst_valid", VW'(win_valid), '0);
        chk("rst_win", win_out, '0);
`ifdef COORD_OUT_EN
        chk("rst_x", VW'(win_x), '0);
        chk("rst_y", VW'(win_y), '0);
`endif
        mr = 0;
        mc = 0;
        #10;
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1;
        pix_valid = 0;
        sof = 0;
        pix_in = '0;
        #7;
        chk("init_valid", VW'(win_valid), '0);
        chk("init_win", win_out, '0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        want_first = 1;
        pulses = 0;
        run_frame(1, 0, 0);
        chk("pulses_s1", VW'(pulses), VW'(24));

        pulses = 0;
        run_frame(1, 30, 0);
        chk("pulses_s2", VW'(pulses), VW'(24));

        for (int i = 0; i < 3 * W + 5; i++)
            step(1, i == 0, pixel_t'((i / W) * 16 + i % W));
        pulses = 0;
        step(1, 1, pixel_t'('h35));
        for (int i = 1; i < W * H; i++)
            step(1, 0, pixel_t'((i / W) * 16 + i % W));
        chk("pulses_s3", VW'(pulses), VW'(24));

        for (int i = 0; i < 4 * W + 4; i++)
            step(1, i == 0, pixel_t'((i / W) * 16 + i % W));
        async_reset();
        want_first = 1;
        pulses = 0;
        run_frame(1, 20, 0);
        chk("pulses_s4", VW'(pulses), VW'(24));

        pulses = 0;
        run_frame(1, 0, 0);
        chk("pulses_s5a", VW'(pulses), VW'(24));
        pulses = 0;
        run_frame(0, 25, 0);
        chk("pulses_s5b", VW'(pulses), VW'(24));

        for (int f = 0; f < 2; f++) begin
            pulses = 0;
            run_frame(f == 0, 35, 1);
            chk("pulses_rnd", VW'(pulses), VW'(24));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
